// File: rtl/apb_rr_sequencer_pkg.sv
// Shared definitions for the APB round-robin sequencer: FSM encoding,
// APB slot map geometry and the PSEL slot decoder.
package apb_rr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int APB_SLOT_HI = 27;
    localparam int APB_SLOT_LO = 24;
    localparam int APB_NSLOT   = 16;

    // Only the slot nibble is decoded; the top address nibble rides along untouched.
    function automatic logic [APB_NSLOT-1:0] slot_sel(input logic [31:0] addr);
        slot_sel = '0;
        slot_sel[addr[APB_SLOT_HI:APB_SLOT_LO]] = 1'b1;
    endfunction

endpackage

// File: rtl/apb_rr_sequencer_pick.sv
// Combinational round-robin picker: first eligible requester at or after
// ptr+1, wrapping modulo NREQ.
module apb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic            gnt_vld,
    output logic [IW-1:0]   gnt_idx
);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IW'((int'(ptr) + off) % NREQ);
            if (elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/apb_rr_sequencer.sv
// Shares one APB master port among NREQ requesters in round-robin order;
// each grant becomes one SETUP+ACCESS transfer with optional timeout.
module apb_rr_sequencer
    import apb_rr_sequencer_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256,
    parameter int TPD     = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NREQ-1:0]      REQ,
    input  logic [32*NREQ-1:0]   REQ_ADDR,
    input  logic [NREQ-1:0]      REQ_WRITE,
    input  logic [32*NREQ-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]      DONE,
    output logic [31:0]          RDATA,
    output logic                 ERR,
    output logic [APB_NSLOT-1:0] PSEL,
    output logic [31:0]          PADDR,
    output logic                 PWRITE,
    output logic                 PENABLE,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // TPD annotates board-level output delay; the registered outputs here are zero-delay.
    if (NREQ < 2 || NREQ > 8 || TPD < 0) begin : g_param_check
        $error("apb_rr_sequencer: NREQ must be 2..8 and TPD non-negative");
    end

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  idx;
    logic [CNT_W-1:0] cnt;
    logic [NREQ-1:0] eligible;
    logic           gnt_vld;
    logic [IW-1:0]  gnt_idx;
    logic           timed_out;
    logic [31:0]    addr_a  [NREQ];
    logic [31:0]    wdata_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g]  = REQ_ADDR[32*g +: 32];
        assign wdata_a[g] = REQ_WDATA[32*g +: 32];
    end

    // A requester being told DONE this cycle is not re-considered until it has reacted.
    assign eligible  = REQ & ~DONE;
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

    apb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .elig    (eligible),
        .ptr     (ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            ptr     <= IW'(NREQ - 1);
            idx     <= '0;
            cnt     <= '0;
            DONE    <= '0;
            RDATA   <= '0;
            ERR     <= 1'b0;
            PSEL    <= '0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PENABLE <= 1'b0;
            PWDATA  <= '0;
        end else begin
            DONE  <= '0;
            RDATA <= '0;
            ERR   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        idx    <= gnt_idx;
                        PADDR  <= addr_a[gnt_idx];
                        PWRITE <= REQ_WRITE[gnt_idx];
                        PWDATA <= wdata_a[gnt_idx];
                        PSEL   <= slot_sel(addr_a[gnt_idx]);
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A slave response in the last allowed cycle beats the timeout.
                    if (PREADY || timed_out) begin
                        RDATA   <= (PREADY && !PWRITE) ? PRDATA : '0;
                        ERR     <= PREADY ? PSLVERR : 1'b1;
                        DONE    <= NREQ'(1) << idx;
                        ptr     <= idx;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_sequencer.sv
// Randomized bench for apb_rr_sequencer against a transaction-timeline
// reference model (grant order, phase lengths, response data).
module tb_apb_rr_sequencer;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic                HCLK = 1'b0;
    logic                HRESET;
    logic [NREQ-1:0]     REQ;
    logic [32*NREQ-1:0]  REQ_ADDR;
    logic [NREQ-1:0]     REQ_WRITE;
    logic [32*NREQ-1:0]  REQ_WDATA;
    logic [NREQ-1:0]     DONE;
    logic [31:0]         RDATA;
    logic                ERR;
    logic [15:0]         PSEL;
    logic [31:0]         PADDR;
    logic                PWRITE;
    logic                PENABLE;
    logic [31:0]         PWDATA;
    logic [31:0]         PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    apb_rr_sequencer #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO),
        .TPD     (1)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .REQ       (REQ),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WRITE (REQ_WRITE),
        .REQ_WDATA (REQ_WDATA),
        .DONE      (DONE),
        .RDATA     (RDATA),
        .ERR       (ERR),
        .PSEL      (PSEL),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    // Requester side
    logic [NREQ-1:0] r_req;
    logic [31:0]     r_addr  [NREQ];
    logic [31:0]     r_wdata [NREQ];
    logic            r_wr    [NREQ];

    // Reference model: one transfer timeline. t=0 SETUP, 1..L ACCESS, L+1 DONE cycle.
    bit          act;
    int          t, L, own, ptr, n_tr, mode;
    bit          tmo;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_wr, m_err;
    int          dut_order[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_op(input int i);
        r_req[i]   = 1'b1;
        r_addr[i]  = $urandom;
        r_wdata[i] = $urandom;
        r_wr[i]    = 1'($urandom_range(0, 1));
    endtask

    task automatic drive();
        REQ = r_req;
        for (int i = 0; i < NREQ; i++) begin
            REQ_ADDR[32*i +: 32]  = r_addr[i];
            REQ_WDATA[32*i +: 32] = r_wdata[i];
            REQ_WRITE[i]          = r_wr[i];
        end
    endtask

    task automatic compare();
        logic [15:0]     e_psel;
        logic            e_pen;
        logic [NREQ-1:0] e_done;
        logic [31:0]     e_rd;
        logic            e_err;
        e_psel = '0; e_pen = 1'b0; e_done = '0; e_rd = '0; e_err = 1'b0;
        if (act && t <= L) begin
            e_psel = 16'd1 << m_addr[27:24];
            e_pen  = (t >= 1);
            chk("PADDR", PADDR, m_addr);
            chk("PWRITE", PWRITE, m_wr);
            chk("PWDATA", PWDATA, m_wdata);
        end else if (act) begin
            e_done = NREQ'(1) << own;
            e_rd   = m_rdata;
            e_err  = m_err;
        end
        chk("PSEL", PSEL, e_psel);
        chk("PENABLE", PENABLE, e_pen);
        chk("DONE", DONE, e_done);
        chk("RDATA", RDATA, e_rd);
        chk("ERR", ERR, e_err);
        for (int i = 0; i < NREQ; i++)
            if (DONE[i]) dut_order.push_back(i);
    endtask

    // One clock: requesters and slave react, model predicts, DUT is sampled.
    task automatic step();
        bit              done_now;
        bit              in_acc;
        logic [NREQ-1:0] done_m;
        logic [NREQ-1:0] el;
        done_now = act && (t == L + 1);
        done_m   = done_now ? (NREQ'(1) << own) : '0;
        for (int i = 0; i < NREQ; i++) begin
            if (done_m[i]) begin
                if (mode == 1 || $urandom_range(0, 1) == 1) new_op(i);
                else r_req[i] = 1'b0;
            end else if (act && !done_now && own == i) begin
                if (mode == 0 && $urandom_range(0, 7) == 0) r_req[i] = 1'b0;
            end else if (!r_req[i]) begin
                if (mode == 1 || $urandom_range(0, 3) == 0) new_op(i);
            end
        end
        drive();

        in_acc  = act && t >= 1 && t <= L;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
        PREADY  = in_acc ? 1'b0 : 1'($urandom_range(0, 1));
        if (in_acc && t == L && !tmo) begin
            PREADY  = 1'b1;
            m_rdata = m_wr ? 32'd0 : PRDATA;
            m_err   = PSLVERR;
        end

        if (act && !done_now) begin
            t++;
            if (t == L + 1) ptr = own;
        end else begin
            el  = r_req & ~done_m;
            act = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (ptr + k) % NREQ;
                if (!act && el[c]) begin
                    own = c;
                    act = 1'b1;
                end
            end
            if (act) begin
                t       = 0;
                m_addr  = r_addr[own];
                m_wdata = r_wdata[own];
                m_wr    = r_wr[own];
                tmo     = (mode == 0) && (n_tr % 7 == 3);
                L       = tmo ? TMO : ((mode == 1) ? 1 : 1 + int'($urandom_range(0, 3)));
                m_rdata = '0;
                m_err   = tmo;
                n_tr++;
            end
        end

        @(posedge HCLK);
        #1;
        compare();
    endtask

    initial begin
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        int guard;
        HRESET = 1'b1;
        r_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_wr[i] = 1'b0;
        end
        drive();
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        act = 1'b0; t = 0; L = 1; own = 0; ptr = NREQ - 1; n_tr = 0; tmo = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_wr = 1'b0; m_err = 1'b0;

        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_PSEL", PSEL, 0);
        chk("rst_PENABLE", PENABLE, 0);
        chk("rst_DONE", DONE, 0);
        chk("rst_RDATA", RDATA, 0);
        chk("rst_ERR", ERR, 0);
        chk("rst_PADDR", PADDR, 0);
        chk("rst_PWRITE", PWRITE, 0);
        chk("rst_PWDATA", PWDATA, 0);
        HRESET = 1'b0;

        // All requesters held, zero-wait slave
        mode = 1;
        dut_order.delete();
        repeat (20) step();
        chk("order_len_ok", dut_order.size() >= 5, 1);
        for (int k = 0; k < 5; k++)
            chk("grant_order", (k < dut_order.size()) ? dut_order[k] : 99, exp_ord[k]);

        // Random traffic, wait states, withdrawals, slave errors, timeouts
        mode = 0;
        repeat (1500) step();

        // Reset during ACCESS
        mode = 1;
        guard = 0;
        while (!(act && t >= 1 && t <= L) && guard < 50) begin
            step();
            guard++;
        end
        chk("reach_access", act && t >= 1 && t <= L, 1);
        #2 HRESET = 1'b1;
        #1;
        chk("arst_PSEL", PSEL, 0);
        chk("arst_PENABLE", PENABLE, 0);
        chk("arst_DONE", DONE, 0);
        act = 1'b0; t = 0; ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) new_op(i);
        drive();
        #3 HRESET = 1'b0;
        dut_order.delete();
        repeat (12) step();
        chk("post_rst_first", (dut_order.size() > 0) ? dut_order[0] : 99, 0);

        mode = 0;
        repeat (200) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
